// File: rtl/xdata_arb.sv
// Round-robin arbiter sharing one data-memory port between N_REQ masters,
// with optional exclusive lock (idle timeout) and fixed 1-cycle responses.
module xdata_arb #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_TMO = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_sel,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMO_W = 4;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TMO - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   lock_own_q, lock_own_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               rsp_we_q;

    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   cand;

    // Modulo-N_REQ increment for pointer wrap.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + IDX_W'(1);
    endfunction

    // Grant selection: owner only while locked, else first valid from rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = rr_ptr_q;
        if (state_q == ST_LOCKED) begin
            if (req_valid[lock_own_q]) begin
                gnt_found = 1'b1;
                gnt_idx   = lock_own_q;
            end
        end else begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                if (!gnt_found && req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
                cand = next_idx(cand);
            end
        end
    end

    // Memory port mux driven by the granted slice.
    always_comb begin
        req_ready = '0;
        mem_sel   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
            mem_sel   = 1'b1;
            mem_we    = req_we[gnt_idx];
            mem_addr  = req_addr[int'(gnt_idx) * int'(ADDR_W) +: ADDR_W];
            mem_wdata = req_wdata[int'(gnt_idx) * int'(DATA_W) +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            lock_own_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_own_q <= lock_own_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Next-state: lock acquisition, release on unlocking access or idle timeout.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_own_d = lock_own_q;
        tmo_cnt_d  = tmo_cnt_q;
        unique case (state_q)
            ST_ARB: begin
                if (gnt_found) begin
                    rr_ptr_d = next_idx(gnt_idx);
                    if (req_lock[gnt_idx]) begin
                        lock_own_d = gnt_idx;
                        tmo_cnt_d  = '0;
                        state_d    = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (gnt_found) begin
                    tmo_cnt_d = '0;
                    if (!req_lock[gnt_idx]) begin
                        state_d  = ST_ARB;
                        rr_ptr_d = next_idx(lock_own_q);
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = ST_ARB;
                    rr_ptr_d  = next_idx(lock_own_q);
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Response pipeline: one pulse per accepted access, next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_we_q  <= 1'b0;
        end else begin
            rsp_valid <= req_ready & req_valid;
            rsp_we_q  <= mem_we;
        end
    end

    assign rsp_rdata = ((|rsp_valid) && !rsp_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_xdata_arb.sv
// Self-checking bench for xdata_arb: directed scenarios plus randomized
// traffic compared every cycle against a behavioural arbitration model.
module tb_xdata_arb;

    localparam int unsigned N   = 2;
    localparam int unsigned AW  = 12;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic            mem_sel, mem_we;
    logic [AW-1:0]   mem_addr;

    xdata_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model state: lock owner, consecutive idle cycles, rotation start.
    bit           m_locked;
    int           m_owner, m_idle, m_rr;
    logic [N-1:0] m_rsp;
    bit           m_rsp_rd;

    int vectors = 0;
    int errors  = 0;

    logic [N-1:0]  cap_ready, cap_rsp;
    logic          cap_sel, cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_rdata;

    function automatic int exp_grant();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (m_rr + k) % int'(N);
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Check one cycle against the model, advance the model, step to next cycle.
    task automatic cycle();
        int            g;
        logic [N-1:0]  er;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #1;
        g  = exp_grant();
        er = '0;
        ew = 1'b0;
        ea = '0;
        ed = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            ew = req_we[g];
            ea = req_addr[g*int'(AW) +: AW];
            ed = req_wdata[g*int'(DW) +: DW];
        end
        cap_ready = req_ready; cap_rsp = rsp_valid; cap_sel = mem_sel;
        cap_we = mem_we; cap_addr = mem_addr; cap_rdata = rsp_rdata;
        check("req_ready", 64'(req_ready), 64'(er));
        check("mem_sel",   64'(mem_sel),   64'(g >= 0));
        check("mem_we",    64'(mem_we),    64'(ew));
        check("mem_addr",  64'(mem_addr),  64'(ea));
        check("mem_wdata", 64'(mem_wdata), 64'(ed));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
        check("rsp_rdata", 64'(rsp_rdata), ((|m_rsp) && m_rsp_rd) ? 64'(mem_rdata) : 64'd0);
        if (rst) begin
            m_locked = 0; m_owner = 0; m_idle = 0; m_rr = 0;
            m_rsp = '0; m_rsp_rd = 0;
        end else begin
            m_rsp    = er;
            m_rsp_rd = (g >= 0) && !req_we[g];
            if (!m_locked) begin
                if (g >= 0) begin
                    m_rr = (g + 1) % int'(N);
                    if (req_lock[g]) begin
                        m_locked = 1; m_owner = g; m_idle = 0;
                    end
                end
            end else if (g >= 0) begin
                m_idle = 0;
                if (!req_lock[g]) begin
                    m_locked = 0; m_rr = (m_owner + 1) % int'(N);
                end
            end else begin
                m_idle++;
                if (m_idle >= int'(TMO)) begin
                    m_locked = 0; m_idle = 0; m_rr = (m_owner + 1) % int'(N);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_we[i]    = we;
        req_lock[i]  = lk;
        req_addr[i*int'(AW) +: AW]  = a;
        req_wdata[i*int'(DW) +: DW] = d;
    endtask

    task automatic idle_all();
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0;
    endtask

    initial begin
        int blocked;
        int p;
        rst = 1'b1;
        mem_rdata = '0;
        idle_all();
        m_locked = 0; m_owner = 0; m_idle = 0; m_rr = 0; m_rsp = '0; m_rsp_rd = 0;
        @(posedge clk); #1;
        cycle();
        cycle();
        check("reset_rsp", 64'(cap_rsp), 64'd0);
        rst = 1'b0;

        // Alternating reads from both masters.
        set_req(0, 1, 0, 0, 12'h010, '0);
        set_req(1, 1, 0, 0, 12'h020, '0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t1_ready", 64'(cap_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            check("t1_addr",  64'(cap_addr),  (k % 2 == 0) ? 64'h010 : 64'h020);
        end

        // Read latency.
        idle_all();
        set_req(0, 1, 0, 0, 12'h005, '0);
        cycle();
        check("t2_accept", 64'(cap_ready), 64'h1);
        idle_all();
        mem_rdata = 32'hDEADBEEF;
        cycle();
        check("t2_rsp",   64'(cap_rsp),   64'h1);
        check("t2_rdata", 64'(cap_rdata), 64'hDEADBEEF);

        // Lock by master0 excludes master1 until unlocking write.
        set_req(0, 1, 0, 1, 12'h030, '0);
        cycle();
        check("t3_lock", 64'(cap_ready), 64'h1);
        set_req(0, 0, 0, 0, '0, '0);
        set_req(1, 1, 0, 0, 12'h040, '0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t3_block", 64'(cap_ready), 64'h0);
        end
        set_req(0, 1, 1, 0, 12'h030, 32'h55);
        cycle();
        check("t3_unlock", 64'(cap_ready), 64'h1);
        set_req(0, 0, 0, 0, '0, '0);
        cycle();
        check("t3_m1_gnt", 64'(cap_ready), 64'h2);

        // Lock timeout.
        idle_all();
        set_req(1, 1, 0, 1, 12'h050, '0);
        cycle();
        check("t4_lock", 64'(cap_ready), 64'h2);
        set_req(1, 0, 0, 0, '0, '0);
        set_req(0, 1, 0, 0, 12'h060, '0);
        blocked = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (cap_ready[0]) break;
            blocked++;
        end
        check("t4_blocked", 64'(blocked), 64'(TMO));
        check("t4_gnt", 64'(cap_ready), 64'h1);

        // Write and its zero-data response.
        idle_all();
        set_req(0, 1, 1, 0, 12'h7FF, 32'h1234);
        cycle();
        check("t5_sel", 64'(cap_sel), 64'h1);
        check("t5_we",  64'(cap_we),  64'h1);
        idle_all();
        mem_rdata = 32'hA5A5A5A5;
        cycle();
        check("t5_rsp",   64'(cap_rsp),   64'h1);
        check("t5_rdata", 64'(cap_rdata), 64'h0);

        // Reset right after an accepted read drops the response.
        set_req(1, 1, 0, 0, 12'h070, '0);
        cycle();
        idle_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("t6_rsp", 64'(cap_rsp), 64'h0);
        set_req(0, 1, 0, 0, 12'h080, '0);
        set_req(1, 1, 0, 0, 12'h090, '0);
        cycle();
        check("t6_gnt", 64'(cap_ready), 64'h1);

        // Randomized traffic; sparse phases exercise lock timeouts.
        for (int blk = 0; blk < 4; blk++) begin
            p = (blk == 0) ? 70 : (blk == 1) ? 40 : (blk == 2) ? 8 : 90;
            for (int c = 0; c < 150; c++) begin
                for (int i = 0; i < int'(N); i++)
                    set_req(i, $urandom_range(99, 0) < p, $urandom_range(1, 0) == 1,
                            $urandom_range(3, 0) == 0, AW'($urandom), $urandom);
                mem_rdata = $urandom;
                rst = ($urandom_range(199, 0) == 0);
                if (rst) idle_all();
                cycle();
            end
        end
        rst = 1'b0;
        idle_all();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
